ram_block_ctrl: RTL and testbench

- Backing-memory stage directly downstream of the cache.
- Consumes the cache's propagated requests (prop_address, prop_read_en, prop_write_data, prop_write_en) against a word-addressed RAM model with fixed, parameterised latencies.
- Returns whole aligned blocks on ram_valid/ram_data for line fills.
- Includes a one-deep pending slot, because the cache has no back-pressure input.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/ram_array.sv | 37 +++
 rtl/ram_block_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ram_block_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache / backing-memory boundary.
package cache_pkg;

  // Field widths of the propagated request bundle; per-instance widths must fit.
  localparam int unsigned REQ_ADDR_BITS = 32;
  localparam int unsigned REQ_DATA_BITS = 64;

  // One propagated request: address, write word and both enables.
  typedef struct packed {
    logic [REQ_ADDR_BITS-1:0] addr;
    logic [REQ_DATA_BITS-1:0] wdata;
    logic                     rd;
    logic                     wr;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_WAIT,
    READ_WAIT,
    RESPOND
  } state_t;

  function automatic int unsigned block_size(input int unsigned block_bits);
    return 32'd1 << block_bits;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Word-addressed storage: synchronous single-word write, combinational block read.
module ram_array
  import cache_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 10,
  parameter int unsigned DATA_BITS    = 32,
  parameter int unsigned BLOCK_BITS   = 2
) (
  input  logic                    clk,
  input  logic                    write_en,
  input  logic [ADDRESS_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0]    write_data,
  input  logic [ADDRESS_BITS-1:0] block_base,
  output logic [DATA_BITS-1:0]    block_data [block_size(BLOCK_BITS)-1:0]
);

  localparam int unsigned DEPTH      = 32'd1 << ADDRESS_BITS;
  localparam int unsigned BLOCK_SIZE = block_size(BLOCK_BITS);

  // Contents start at zero; there is deliberately no reset of the array.
  logic [DATA_BITS-1:0] mem [DEPTH] = '{default: '0};

  // Single-word write port
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_address] <= write_data;
    end
  end

  // Aligned block read: base is already aligned, so base+i never wraps
  always_comb begin
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
      block_data[i] = mem[block_base + ADDRESS_BITS'(i)];
    end
  end

endmodule

// File: rtl/ram_block_ctrl.sv
// Backing-memory controller behind the cache: fixed-latency writes and block
// reads, with a one-deep pending slot since the cache cannot be stalled.
module ram_block_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned RAM_ADDRESS_BITS = 10,
  parameter int unsigned DATA_BITS        = 32,
  parameter int unsigned BLOCK_BITS       = 2,
  parameter int unsigned READ_LATENCY     = 4,
  parameter int unsigned WRITE_LATENCY    = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [RAM_ADDRESS_BITS-1:0] prop_address,
  input  logic                        prop_read_en,
  input  logic [DATA_BITS-1:0]        prop_write_data,
  input  logic                        prop_write_en,
  output logic                        ram_valid,
  output logic [DATA_BITS-1:0]        ram_data [block_size(BLOCK_BITS)-1:0],
  output logic                        busy,
  output logic                        overflow
);

  localparam int unsigned BLOCK_SIZE = block_size(BLOCK_BITS);
  localparam int unsigned CNT_BITS   = $clog2(max_u(READ_LATENCY, WRITE_LATENCY) + 1);
  localparam logic [CNT_BITS-1:0] RD_LAST = CNT_BITS'(READ_LATENCY);
  localparam logic [CNT_BITS-1:0] WR_LAST = CNT_BITS'(WRITE_LATENCY);
  localparam logic [RAM_ADDRESS_BITS-1:0] BLOCK_MASK = ~RAM_ADDRESS_BITS'(BLOCK_SIZE - 1);

  if (READ_LATENCY < 1) begin : g_bad_read_latency
    $error("ram_block_ctrl: READ_LATENCY must be >= 1");
  end
  if (WRITE_LATENCY < 1) begin : g_bad_write_latency
    $error("ram_block_ctrl: WRITE_LATENCY must be >= 1");
  end
  if (BLOCK_BITS > RAM_ADDRESS_BITS) begin : g_bad_block_bits
    $error("ram_block_ctrl: BLOCK_BITS must not exceed RAM_ADDRESS_BITS");
  end
  if (RAM_ADDRESS_BITS > REQ_ADDR_BITS || DATA_BITS > REQ_DATA_BITS) begin : g_bad_req_width
    $error("ram_block_ctrl: address/data width exceeds request bundle");
  end

  state_t                      state;
  logic [CNT_BITS-1:0]         cnt;
  req_t                        active;
  req_t                        pend;
  logic                        pend_valid;

  req_t                        incoming;
  req_t                        launch_req;
  logic                        req_present;
  logic                        wr_done;
  logic                        rd_done;
  logic                        finish;
  logic                        launch;
  logic                        capture;
  logic                        drop;

  logic [RAM_ADDRESS_BITS-1:0] active_addr;
  logic [DATA_BITS-1:0]        active_wdata;
  logic [RAM_ADDRESS_BITS-1:0] block_base;
  logic                        mem_we;
  logic [DATA_BITS-1:0]        block [BLOCK_SIZE-1:0];
  logic                        unused_req_bits;

  assign active_addr     = active.addr[RAM_ADDRESS_BITS-1:0];
  assign active_wdata    = active.wdata[DATA_BITS-1:0];
  assign block_base      = active_addr & BLOCK_MASK;
  // Reset on the commit edge discards the in-flight write.
  assign mem_we          = wr_done & reset_n;
  assign unused_req_bits = ^{active, pend};

  ram_array #(
    .ADDRESS_BITS (RAM_ADDRESS_BITS),
    .DATA_BITS    (DATA_BITS),
    .BLOCK_BITS   (BLOCK_BITS)
  ) u_ram_array (
    .clk           (clk),
    .write_en      (mem_we),
    .write_address (active_addr),
    .write_data    (active_wdata),
    .block_base    (block_base),
    .block_data    (block)
  );

  // Request decode, phase completion and pending-slot / launch decisions
  always_comb begin
    incoming       = '0;
    incoming.addr  = REQ_ADDR_BITS'(prop_address);
    incoming.wdata = REQ_DATA_BITS'(prop_write_data);
    incoming.rd    = prop_read_en;
    incoming.wr    = prop_write_en;
    req_present    = prop_read_en | prop_write_en;

    wr_done = (state == WRITE_WAIT) && (cnt == WR_LAST);
    rd_done = (state == READ_WAIT) && (cnt == RD_LAST);
    finish  = (state == RESPOND) || (wr_done && !active.rd);

    launch     = 1'b0;
    launch_req = incoming;
    if (state == IDLE) begin
      launch = req_present;
    end else if (finish) begin
      if (pend_valid) begin
        launch     = 1'b1;
        launch_req = pend;
      end else begin
        launch = req_present;
      end
    end

    // A request meeting a full slot is lost, even on the edge the slot drains.
    capture = req_present && (state != IDLE) && !finish && !pend_valid;
    drop    = req_present && (state != IDLE) && pend_valid;
  end

  // Controller FSM, latency counter, pending slot and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      active     <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      ram_valid  <= 1'b0;
      ram_data   <= '{default: '0};
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ram_valid <= 1'b0;
      overflow  <= overflow | drop;

      if (capture) begin
        pend       <= incoming;
        pend_valid <= 1'b1;
      end else if (finish && pend_valid) begin
        pend_valid <= 1'b0;
      end

      if (launch) begin
        active <= launch_req;
        cnt    <= CNT_BITS'(1);
        state  <= launch_req.wr ? WRITE_WAIT : READ_WAIT;
        busy   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          WRITE_WAIT: begin
            if (wr_done) begin
              if (active.rd) begin
                state <= READ_WAIT;
                cnt   <= CNT_BITS'(1);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_BITS'(1);
            end
          end
          READ_WAIT: begin
            if (rd_done) begin
              ram_data  <= block;
              ram_valid <= 1'b1;
              state     <= RESPOND;
            end else begin
              cnt <= cnt + CNT_BITS'(1);
            end
          end
          RESPOND: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_block_ctrl.sv
// Self-checking bench for ram_block_ctrl: default configuration and a
// READ_LATENCY=1 / WRITE_LATENCY=1 / BLOCK_BITS=0 configuration, run in turn.
module tb_ram_block_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic        sel;

  always #5 clk = ~clk;

  // DUT A: default configuration
  logic        a_rd, a_wr, a_valid, a_busy, a_ovf;
  logic [31:0] a_data [3:0];
  assign a_rd = rd & ~sel;
  assign a_wr = wr & ~sel;

  ram_block_ctrl #(
    .RAM_ADDRESS_BITS (10),
    .DATA_BITS        (32),
    .BLOCK_BITS       (2),
    .READ_LATENCY     (4),
    .WRITE_LATENCY    (2)
  ) dut_a (
    .clk             (clk),
    .reset_n         (reset_n),
    .prop_address    (addr),
    .prop_read_en    (a_rd),
    .prop_write_data (wdata),
    .prop_write_en   (a_wr),
    .ram_valid       (a_valid),
    .ram_data        (a_data),
    .busy            (a_busy),
    .overflow        (a_ovf)
  );

  // DUT B: minimum latencies, single-word blocks
  logic        b_rd, b_wr, b_valid, b_busy, b_ovf;
  logic [31:0] b_data [0:0];
  assign b_rd = rd & sel;
  assign b_wr = wr & sel;

  ram_block_ctrl #(
    .RAM_ADDRESS_BITS (10),
    .DATA_BITS        (32),
    .BLOCK_BITS       (0),
    .READ_LATENCY     (1),
    .WRITE_LATENCY    (1)
  ) dut_b (
    .clk             (clk),
    .reset_n         (reset_n),
    .prop_address    (addr),
    .prop_read_en    (b_rd),
    .prop_write_data (wdata),
    .prop_write_en   (b_wr),
    .ram_valid       (b_valid),
    .ram_data        (b_data),
    .busy            (b_busy),
    .overflow        (b_ovf)
  );

  logic cur_valid, cur_busy, cur_ovf;
  assign cur_valid = sel ? b_valid : a_valid;
  assign cur_busy  = sel ? b_busy  : a_busy;
  assign cur_ovf   = sel ? b_ovf   : a_ovf;

  function automatic logic [31:0] cur_word(input int unsigned i);
    if (sel) return b_data[0];
    return a_data[i[1:0]];
  endfunction

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned rl, wl, bsize;
  logic [31:0] model_mem [1024];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned     due;
    logic [3:0][31:0] blk;
  } exp_t;
  exp_t sbq[$];
  exp_t got;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic        r;
    logic        w;
    logic [31:0] exp_word;
    string       name;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (sel=%0d cyc=%0d)", name, act, exp, sel, cyc);
    end
  endtask

  // Scoreboard consumer: every ram_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (cur_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 (sel=%0d cyc=%0d)", sel, cyc);
      end else begin
        got = sbq.pop_front();
        chk("valid_cycle", cyc, got.due);
        for (int unsigned i = 0; i < bsize; i++) begin
          chk("block_word", cur_word(i), got.blk[i]);
        end
      end
    end
  end

  task automatic push_read(input logic [9:0] a, input int unsigned lat);
    exp_t        e;
    int unsigned base;
    base  = int'(a) & ~(bsize - 1);
    e.due = cyc + 1 + lat;
    e.blk = '0;
    for (int unsigned i = 0; i < bsize; i++) e.blk[i] = model_mem[base + i];
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [9:0] a, input logic [31:0] d, input logic r, input logic w);
    addr  = a;
    wdata = d;
    rd    = r;
    wr    = w;
  endtask

  task automatic count_busy(output int unsigned n);
    n = 0;
    while (cur_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=%0d required<100", n);
    end
  endtask

  task automatic run_op(input vec_t v);
    int unsigned n, exp_n, idx;
    @(negedge clk);
    drive(v.a, v.d, v.r, v.w);
    if (v.w) model_mem[v.a] = v.d;
    if (v.r) push_read(v.a, (v.w ? wl : 0) + rl);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    count_busy(n);
    exp_n = (v.r && v.w) ? wl + rl + 1 : (v.r ? rl + 1 : wl);
    chk({v.name, "_busy_cycles"}, n, exp_n);
    repeat (3) @(negedge clk);
    chk({v.name, "_sb_drained"}, sbq.size(), 0);
    if (v.r) begin
      idx = int'(v.a) & (bsize - 1);
      chk(v.name, cur_word(idx), v.exp_word);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(cur_valid), 0);
    chk({tag, "_busy"}, 32'(cur_busy), 0);
    chk({tag, "_overflow"}, 32'(cur_ovf), 0);
    for (int unsigned i = 0; i < bsize; i++) chk({tag, "_data"}, cur_word(i), 0);
  endtask

  task automatic run_variant(input logic s);
    int unsigned n, c0;
    sel   = s;
    rl    = s ? 1 : 4;
    wl    = s ? 1 : 2;
    bsize = s ? 1 : 4;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;

    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(vecs[i]);
    chk("overflow_clean", 32'(cur_ovf), 0);

    // Burst of three reads: first two chain with no bubble, third is dropped
    @(negedge clk);
    c0 = cyc;
    drive(10'h010, '0, 1'b1, 1'b0);
    push_read(10'h010, rl);
    @(negedge clk);
    chk("burst_busy0", 32'(cur_busy), 1);
    drive(10'h020, '0, 1'b1, 1'b0);
    sbq.push_back('{due: c0 + 1 + rl + 1 + rl, blk: '0});
    sbq[sbq.size() - 1].blk[0] = (bsize == 1) ? model_mem[10'h020] : model_mem[10'h020];
    @(negedge clk);
    chk("burst_busy1", 32'(cur_busy), 1);
    drive(10'h030, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    count_busy(n);
    chk("burst_busy_cycles", n + 2, 2 * (rl + 1));
    chk("burst_sb_drained", sbq.size(), 0);
    chk("burst_overflow", 32'(cur_ovf), 1);
    repeat (5) @(negedge clk);
    chk("overflow_sticky", 32'(cur_ovf), 1);

    // Reset while a write is waiting to commit: the write is lost
    @(negedge clk);
    drive(10'h050, 32'hFFFF_FFFF, 1'b0, 1'b1);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    chk("wr_inflight_busy", 32'(cur_busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midwrite_reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    run_op('{10'h050, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D, "rd_050_after_reset"});
  endtask

  initial begin
    reset_n = 1'b0;
    sel     = 1'b0;
    drive('0, '0, 1'b0, 1'b0);

    vecs[0]  = '{10'h000, 32'h0,         1'b1, 1'b0, 32'h0,         "rd_000"};
    vecs[1]  = '{10'h00D, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,         "wr_00d"};
    vecs[2]  = '{10'h00C, 32'h0,         1'b1, 1'b0, 32'h0,         "rd_00c"};
    vecs[3]  = '{10'h00D, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, "rd_00d"};
    vecs[4]  = '{10'h102, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678, "rw_102"};
    vecs[5]  = '{10'h3FF, 32'hA5A5_5A5A, 1'b0, 1'b1, 32'h0,         "wr_3ff"};
    vecs[6]  = '{10'h3FC, 32'h0,         1'b1, 1'b0, 32'h0,         "rd_3fc"};
    vecs[7]  = '{10'h3FF, 32'h0,         1'b1, 1'b0, 32'hA5A5_5A5A, "rd_3ff"};
    vecs[8]  = '{10'h050, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h0,         "wr_050"};
    vecs[9]  = '{10'h101, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0,         "wr_101"};
    vecs[10] = '{10'h103, 32'h0,         1'b1, 1'b0, 32'h0,         "rd_103"};
    vecs[11] = '{10'h101, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D, "rd_101"};

    run_variant(1'b0);
    run_variant(1'b1);

    @(negedge clk);
    chk("final_sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
